// File: rtl/regfile_wr_arb.sv
// Arbitrates the single regfile write port between the W-stage pipeline write and a 2-deep mul/div result FIFO.
// Optional macro REGFILE_WR_ARB_BYPASS_EN: an aux offer arriving at an empty FIFO on an idle port writes through in the same cycle.
module regfile_wr_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_wa,
  input  logic [31:0] pipe_wd,
  input  logic        stallW,
  input  logic        aux_valid,
  input  logic [4:0]  aux_wa,
  input  logic [31:0] aux_wd,
  output logic        aux_ready,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        pend_hit1,
  output logic        pend_hit2,
  output logic        stall_req
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Entry 0 is always the head; valid entries are kept contiguous from 0.
  logic [1:0]  vld_q, kill_q, vld_d, kill_d, hit;
  logic [4:0]  wa_q [2];
  logic [4:0]  wa_d [2];
  logic [31:0] wd_q [2];
  logic [31:0] wd_d [2];
  logic [3:0]  starve_q, starve_d;
  logic        pw, pop, enq, byp;

  assign pw        = pipe_we & ~stallW & (pipe_wa != 5'd0);
  assign aux_ready = ~vld_q[1];
  assign pop       = ~pw & vld_q[0] & ~rst;

`ifdef REGFILE_WR_ARB_BYPASS_EN
  assign byp = aux_valid & ~vld_q[0] & ~pw & ~rst;
`else
  assign byp = 1'b0;
`endif

  assign enq = aux_valid & aux_ready & ~byp;

  // The pipeline write is younger than anything already queued, so it kills matching entries.
  assign hit[0] = pw & vld_q[0] & (wa_q[0] == pipe_wa);
  assign hit[1] = pw & vld_q[1] & (wa_q[1] == pipe_wa);

  assign pend_hit1 = (ra1 != 5'd0) &
                     ((vld_q[0] & ~kill_q[0] & (wa_q[0] == ra1)) |
                      (vld_q[1] & ~kill_q[1] & (wa_q[1] == ra1)));
  assign pend_hit2 = (ra2 != 5'd0) &
                     ((vld_q[0] & ~kill_q[0] & (wa_q[0] == ra2)) |
                      (vld_q[1] & ~kill_q[1] & (wa_q[1] == ra2)));

  always_comb begin
    rf_we = 1'b0;
    rf_wa = 5'd0;
    rf_wd = 32'd0;
    if (pw) begin
      rf_we = 1'b1;
      rf_wa = pipe_wa;
      rf_wd = pipe_wd;
    end else if (pop) begin
      rf_we = ~kill_q[0] & (wa_q[0] != 5'd0);
      rf_wa = wa_q[0];
      rf_wd = wd_q[0];
    end else if (byp) begin
      rf_we = (aux_wa != 5'd0);
      rf_wa = aux_wa;
      rf_wd = aux_wd;
    end
  end

  always_comb begin
    vld_d  = vld_q;
    kill_d = kill_q | hit;
    wa_d   = wa_q;
    wd_d   = wd_q;
    if (pop) begin
      vld_d  = {1'b0, vld_q[1]};
      kill_d = {1'b0, kill_q[1] | hit[1]};
      wa_d[0] = wa_q[1];
      wd_d[0] = wd_q[1];
    end
    // A newly accepted entry is never killed by a same-cycle pipeline write; it is younger.
    if (enq) begin
      if (vld_d[0]) begin
        vld_d[1]  = 1'b1;
        kill_d[1] = (aux_wa == 5'd0);
        wa_d[1]   = aux_wa;
        wd_d[1]   = aux_wd;
      end else begin
        vld_d[0]  = 1'b1;
        kill_d[0] = (aux_wa == 5'd0);
        wa_d[0]   = aux_wa;
        wd_d[0]   = aux_wd;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (pop || !vld_q[0])
      starve_d = 4'd0;
    else if (starve_q != 4'hf)
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= 2'b00;
      kill_q    <= 2'b00;
      starve_q  <= 4'd0;
      stall_req <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      kill_q    <= kill_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      starve_q  <= starve_d;
      stall_req <= (starve_d >= LIMIT);
    end
  end

endmodule

// File: doc/regfile_wr_arb.md
REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, giving the consecutive undrained cycles before stall_req asserts (range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports pipe_we/pipe_wa/pipe_wd, input, 1/5/32 bits: the pipeline W-stage write request, address and data.
REQ-005 The block SHALL have port stallW, input, 1 bit: W stage frozen; the pipeline write is ignored while high.
REQ-006 The block SHALL have ports aux_valid/aux_wa/aux_wd, input, 1/5/32 bits: the long-latency unit's (mul/div) result offer.
REQ-007 The block SHALL have port aux_ready, output, 1 bit: the aux offer is accepted on an edge where aux_valid & aux_ready.
REQ-008 The block SHALL have ports rf_we/rf_wa/rf_wd, output, 1/5/32 bits: the single write port to regfile (regfile stallW tied 0).
REQ-009 The block SHALL have ports ra1/ra2, input, 5 bits each, and pend_hit1/pend_hit2, output, 1 bit each: read address has a live pending aux write.
REQ-010 The block SHALL have port stall_req, output, 1 bit: request to the hazard unit to freeze W so the aux buffer drains.

Function
REQ-011 The effective pipeline write pw SHALL be pipe_we & ~stallW & (pipe_wa != 0); pw has absolute priority, passing combinationally to rf_* with zero latency.
REQ-012 Aux results SHALL be held in a 2-entry in-order FIFO; each entry holds wa, wd, valid and kill bits.
REQ-013 aux_ready SHALL equal (FIFO occupancy < 2) from registered state only; no enqueue while full, even with a same-cycle pop.
REQ-014 In a cycle where pw=0 and the FIFO is non-empty, the head SHALL be popped at the edge; rf_we = ~kill & (wa != 0), rf_wa/rf_wd = head fields.
REQ-015 Enqueue and pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-016 When pw=1, every valid entry with wa == pipe_wa SHALL have its kill bit set at the edge, because the pipeline write is younger; killed entries still pop in order but never write.
REQ-017 An aux offer with aux_wa == 0 SHALL be accepted and enqueued pre-killed.
REQ-018 An aux offer accepted in the same cycle as pw=1 to the same address SHALL NOT be killed; it is younger.
REQ-019 pend_hit1 SHALL be (ra1 != 0) & any(valid & ~kill & wa == ra1); pend_hit2 SHALL be the same for ra2; both combinational.
REQ-020 A 4-bit starve counter SHALL increment, saturating at 15, each cycle the FIFO is non-empty and no pop occurs; it SHALL clear on any pop or when the FIFO is empty.
REQ-021 stall_req SHALL be registered and equal (starve counter >= STARVE_LIMIT); it deasserts the cycle after the first pop.
REQ-022 When pw=0 and nothing is popped, rf_we SHALL be 0, and rf_wa/rf_wd SHALL be 0.

Reset
REQ-023 While rst is high at an edge, the FIFO SHALL empty (all valid/kill bits 0) and the starve counter and stall_req SHALL become 0; aux_ready reads 1 after reset.
REQ-024 Reset SHALL override every same-edge enqueue, pop or kill; entries pending mid-operation are discarded without writing.
REQ-025 rf_we during rst high SHALL still follow REQ-011 (pass-through is combinational); pops SHALL be suppressed.

Configuration
REQ-026 With macro REGFILE_WR_ARB_BYPASS_EN defined, an aux offer accepted while the FIFO is empty and pw=0 SHALL write straight to rf_* in the same cycle and not be enqueued; pend_hit is not asserted for it.
REQ-027 Without REGFILE_WR_ARB_BYPASS_EN, every aux result SHALL pass through the FIFO, so the minimum aux-to-rf_we latency is 1 cycle.

Verification
REQ-028 Bypass off, idle pipe: aux_valid with wa=5, wd=0x1234 at cycle 0 -> rf_we=1, rf_wa=5, rf_wd=0x1234 in cycle 1; pend_hit1=1 in cycle 1 for ra1=5.
REQ-029 pw=1 continuously to wa=3, two aux offers (wa=7, 8) -> aux_ready=0 after 2 accepts; stall_req=1 after 4 undrained cycles; stallW=1 -> pops 7 then 8 in order; stall_req drops.
REQ-030 aux entry wa=9 pending, then pw to wa=9 with data 0xAAAA -> rf writes 0xAAAA; the entry later pops with rf_we=0; pend_hit for 9 clears immediately after the kill edge.
REQ-031 aux offer wa=0 -> accepted, popped with rf_we=0; pipe_wa=0 with pipe_we=1 -> rf_we=0 and slot used for a drain.
REQ-032 FIFO full, rst pulsed 1 cycle -> no rf_we from aux, aux_ready=1, stall_req=0 next cycle.
REQ-033 Bypass on, empty FIFO, pw=0: aux wa=4, wd=0x55 -> rf_we=1 with those values in the same cycle; with pw=1 the offer enqueues instead.
